// File: rtl/fft16_pkg.sv
// Shared constants and FSM encoding for the 16-point FFT butterfly scheduler.
package fft16_pkg;
  localparam int unsigned N     = 16;
  localparam int unsigned LOG2N = 4;
  localparam logic [31:0] ANGLE_STEP = 32'h1000_0000;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;
endpackage

// File: rtl/fft16_agu.sv
// Radix-2 DIT butterfly address and twiddle-angle generator (pure combinational).
module fft16_agu
  import fft16_pkg::*;
(
  input  logic [1:0]         stage,
  input  logic [LOG2N-2:0]   j,
  output logic [LOG2N-1:0]   a,
  output logic [LOG2N-1:0]   b,
  output logic signed [31:0] zangle
);
  logic [LOG2N-1:0] span;
  logic [LOG2N-1:0] pos;
  logic [LOG2N-1:0] grp;
  logic [LOG2N-1:0] k;

  always_comb begin
    span = 4'd1 << stage;
    pos  = {1'b0, j} & (span - 4'd1);
    grp  = {1'b0, j} >> stage;
    a    = (grp << ({1'b0, stage} + 3'd1)) | pos;
    b    = a + span;
    // Twiddle exponent scaled to the 16-point circle; rotation is clockwise.
    k      = pos << (2'd3 - stage);
    zangle = '0 - (ANGLE_STEP * {28'd0, k});
  end
endmodule

// File: rtl/fft16_sched.sv
// Four-stage butterfly issue scheduler with a LAT-cycle write-back delay line.
module fft16_sched
  import fft16_pkg::*;
#(
  parameter int unsigned LAT = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               rd_en,
  output logic [3:0]         rd_addr_a,
  output logic [3:0]         rd_addr_b,
  output logic signed [31:0] zangle,
  output logic [1:0]         stage,
  output logic               wr_en,
  output logic [3:0]         wr_addr_a,
  output logic [3:0]         wr_addr_b
);
  state_t           state, state_nx;
  logic [2:0]       j;
  logic [1:0]       stg;
  logic [6:0]       dcnt;
  logic             drain_end;
  logic [3:0]       agu_a, agu_b;
  logic signed [31:0] agu_z;
  logic [8:0]       dly [LAT];

  fft16_agu u_agu (
    .stage  (stg),
    .j      (j),
    .a      (agu_a),
    .b      (agu_b),
    .zangle (agu_z)
  );

  assign drain_end = (dcnt == 7'(LAT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = ISSUE;
      ISSUE: if (j == 3'd7) state_nx = DRAIN;
      DRAIN: if (drain_end) state_nx = (stg == 2'd3) ? DONE : ISSUE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      j    <= '0;
      stg  <= '0;
      dcnt <= '0;
    end else begin
      case (state)
        ISSUE: begin
          j    <= j + 3'd1;
          dcnt <= '0;
        end
        DRAIN: begin
          if (drain_end) begin
            dcnt <= '0;
            stg  <= stg + 2'd1;
          end else begin
            dcnt <= dcnt + 7'd1;
          end
        end
        default: begin
          j    <= '0;
          stg  <= '0;
          dcnt <= '0;
        end
      endcase
    end
  end

  // Addresses are already zeroed when idle, so the delay line carries clean zeros.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < LAT; i++) dly[i] <= '0;
    end else begin
      dly[0] <= {rd_en, rd_addr_a, rd_addr_b};
      for (int unsigned i = 1; i < LAT; i++) dly[i] <= dly[i-1];
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    rd_en     = (state == ISSUE);
    stage     = (state == ISSUE || state == DRAIN) ? stg : '0;
    rd_addr_a = rd_en ? agu_a : '0;
    rd_addr_b = rd_en ? agu_b : '0;
    zangle    = rd_en ? agu_z : '0;
    {wr_en, wr_addr_a, wr_addr_b} = dly[LAT-1];
  end
endmodule

// File: tb/tb_fft16_sched.sv
// Randomized self-checking bench for fft16_sched against a cycle-indexed schedule model.
module tb_fft16_sched;
  typedef struct packed {
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [31:0] z;
    logic [1:0]  stage;
    logic        wr_en;
    logic [3:0]  wa;
    logic [3:0]  wb;
  } obs_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start16 = 1'b0;
  logic start1 = 1'b0;

  logic busy16, done16, rd16, wr16;
  logic [3:0] ra16, rb16, wa16, wb16;
  logic signed [31:0] z16;
  logic [1:0] st16;
  logic busy1, done1, rd1, wr1;
  logic [3:0] ra1, rb1, wa1, wb1;
  logic signed [31:0] z1;
  logic [1:0] st1;

  obs_t o16, o1;
  int ntests = 0;
  int nfail = 0;

  always #5 clock = ~clock;

  fft16_sched #(.LAT(16)) dut16 (
    .clock(clock), .reset(reset), .start(start16), .busy(busy16), .done(done16),
    .rd_en(rd16), .rd_addr_a(ra16), .rd_addr_b(rb16), .zangle(z16), .stage(st16),
    .wr_en(wr16), .wr_addr_a(wa16), .wr_addr_b(wb16)
  );

  fft16_sched #(.LAT(1)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .busy(busy1), .done(done1),
    .rd_en(rd1), .rd_addr_a(ra1), .rd_addr_b(rb1), .zangle(z1), .stage(st1),
    .wr_en(wr1), .wr_addr_a(wa1), .wr_addr_b(wb1)
  );

  assign o16 = {busy16, done16, rd16, ra16, rb16, z16, st16, wr16, wa16, wb16};
  assign o1  = {busy1, done1, rd1, ra1, rb1, z1, st1, wr1, wa1, wb1};

  // Butterfly j of stage s in a 16-point radix-2 DIT transform.
  function automatic void bfly(input int s, input int j, output logic [3:0] a,
                               output logic [3:0] b, output logic [31:0] z);
    int span, pos, ai, k;
    span = 2 ** s;
    pos  = j % span;
    ai   = (j / span) * 2 * span + pos;
    k    = pos * (8 / span);
    a    = 4'(ai);
    b    = 4'(ai + span);
    z    = 32'(0 - k * 268435456);
  endfunction

  // Expected outputs in cycle t of a run whose start was accepted in cycle 0.
  function automatic obs_t model(input int t, input int lat);
    obs_t e;
    int per, fin, tw;
    logic [31:0] zz;
    e   = '0;
    per = 8 + lat;
    fin = 33 + 4 * lat;
    if (t >= 1 && t < fin) begin
      e.busy  = 1'b1;
      e.stage = 2'((t - 1) / per);
      if ((t - 1) % per < 8) begin
        e.rd_en = 1'b1;
        bfly((t - 1) / per, (t - 1) % per, e.a, e.b, e.z);
      end
    end else if (t == fin) begin
      e.busy = 1'b1;
      e.done = 1'b1;
    end
    tw = t - lat;
    if (tw >= 1 && tw < fin && (tw - 1) % per < 8) begin
      e.wr_en = 1'b1;
      bfly((tw - 1) / per, (tw - 1) % per, e.wa, e.wb, zz);
    end
    return e;
  endfunction

  function automatic obs_t pick(input int sel);
    return (sel == 1) ? o1 : o16;
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 1) start1 = v;
    else          start16 = v;
  endtask

  // One transform; noise pulses start while busy, b2b leaves start raised in the cycle after done.
  task automatic run_xform(input int sel, input int lat, input bit prestarted,
                           input bit noise, input bit b2b);
    obs_t e, o;
    int per, fin, last, rdc, wrc, done_t, wr8_t, rd9_t;
    per = 8 + lat;
    fin = 33 + 4 * lat;
    last = b2b ? fin + 1 : fin + 3;
    rdc = 0; wrc = 0; done_t = -1; wr8_t = -1; rd9_t = -1;
    if (!prestarted) begin
      @(negedge clock);
      set_start(sel, 1'b1);
    end
    @(negedge clock);
    set_start(sel, 1'b0);
    for (int t = 1; t <= last; t++) begin
      if (t > 1) @(negedge clock);
      o = pick(sel);
      e = model(t, lat);
      ntests++;
      if (o !== e) begin
        nfail++;
        $display("FAIL sched lat=%0d t=%0d got=%h exp=%h", lat, t, o, e);
      end
      if (t >= 1 && t <= 8) begin
        ntests++;
        if ({o.a, o.b, o.z} !== {4'(2 * (t - 1)), 4'(2 * t - 1), 32'h0}) begin
          nfail++;
          $display("FAIL stage0_addr t=%0d got a=%0d b=%0d z=%h", t, o.a, o.b, o.z);
        end
      end
      if (t == 2 + per) begin
        ntests++;
        if ({o.a, o.b, o.z} !== {4'd1, 4'd3, 32'hC000_0000}) begin
          nfail++;
          $display("FAIL s1j1 got a=%0d b=%0d z=%h exp 1 3 c0000000", o.a, o.b, o.z);
        end
      end
      if (t == 4 + 3 * per) begin
        ntests++;
        if ({o.a, o.b, o.z} !== {4'd3, 4'd11, 32'hD000_0000}) begin
          nfail++;
          $display("FAIL s3j3 got a=%0d b=%0d z=%h exp 3 11 d0000000", o.a, o.b, o.z);
        end
      end
      if (o.rd_en === 1'b1) begin
        rdc++;
        if (rdc == 9) rd9_t = t;
      end
      if (o.wr_en === 1'b1) begin
        wrc++;
        if (wrc == 8) wr8_t = t;
      end
      if (o.done === 1'b1 && done_t < 0) done_t = t;
      if (noise && t <= fin && ($urandom % 3 == 0)) set_start(sel, 1'b1);
      else if (b2b && t == fin + 1) set_start(sel, 1'b1);
      else set_start(sel, 1'b0);
    end
    if (!b2b) set_start(sel, 1'b0);
    ntests++;
    if (done_t != fin) begin
      nfail++;
      $display("FAIL done_cycle lat=%0d got=%0d exp=%0d", lat, done_t, fin);
    end
    ntests++;
    if (rdc != 32 || wrc != 32) begin
      nfail++;
      $display("FAIL pulse_count lat=%0d got rd=%0d wr=%0d exp 32 32", lat, rdc, wrc);
    end
    ntests++;
    if (rd9_t - wr8_t != 1) begin
      nfail++;
      $display("FAIL raw_gap lat=%0d got=%0d exp=1", lat, rd9_t - wr8_t);
    end
  endtask

  task automatic test_reset;
    @(negedge clock);
    ntests++;
    if (o16 !== '0 || o1 !== '0) begin
      nfail++;
      $display("FAIL reset_state got=%h/%h exp=0", o16, o1);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_mid_reset;
    int stop_t;
    stop_t = 2 + int'($urandom_range(0, 5));
    @(negedge clock);
    start16 = 1'b1;
    @(negedge clock);
    start16 = 1'b0;
    repeat (stop_t) @(negedge clock);
    #1 reset = 1'b1;
    #1;
    ntests++;
    if (o16 !== '0) begin
      nfail++;
      $display("FAIL midreset_async got=%h exp=0", o16);
    end
    @(negedge clock);
    start16 = 1'b1;
    @(negedge clock);
    ntests++;
    if (o16 !== '0) begin
      nfail++;
      $display("FAIL midreset_hold got=%h exp=0", o16);
    end
    start16 = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      ntests++;
      if (o16 !== '0) begin
        nfail++;
        $display("FAIL after_reset i=%0d got=%h exp=0", i, o16);
      end
    end
  endtask

  task automatic test_stages;
    run_xform(16, 16, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_lat1;
    run_xform(1, 1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_start_noise;
    repeat ($urandom_range(0, 4)) @(negedge clock);
    run_xform(16, 16, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_xform(16, 16, 1'b0, 1'b1, 1'b1);
    run_xform(16, 16, 1'b1, 1'b0, 1'b1);
    run_xform(1, 1, 1'b0, 1'b1, 1'b1);
    run_xform(1, 1, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset;
    test_stages;
    test_mid_reset;
    test_lat1;
    test_start_noise;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
